// File: rtl/baseline_sample_serializer.sv
// baseline_sample_serializer: buffers 16-lane baseline-removed beats in a
// small FIFO and replays them one sample per cycle on a ready/valid stream.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_data   packed input beat, lane 0 oldest; no backpressure
//   out_valid/out_ready sample handshake
//   out_data, out_last  current sample, end-of-packet marker
//   overflow            sticky beat-drop flag, cleared by clr_overflow
//   fifo_level          beats held, including the one being serialized
module baseline_sample_serializer #(
  parameter int DATA_OUTPUT = 17,
  parameter int LANES       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PKT_BEATS   = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_OUTPUT*LANES-1:0]    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_OUTPUT-1:0]          out_data,
  output logic                            out_last,
  output logic                            overflow,
  input  logic                            clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int LW     = PW + 1;
  localparam int NW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW     = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int BEAT_W = DATA_OUTPUT * LANES;

  logic [BEAT_W-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [NW-1:0] lane_q, lane_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          overflow_q, overflow_d;

  logic              valid;
  logic              xfer;
  logic              lane_end;
  logic              pop;
  logic              push;
  logic              drop;
  logic [BEAT_W-1:0] head;

  always_comb begin
    valid    = (level_q != '0);
    xfer     = valid && out_ready;
    lane_end = (lane_q == NW'(LANES - 1));
    pop      = xfer && lane_end;
    // A pop in the same cycle frees the head slot, so a full FIFO
    // still accepts a beat arriving with the final-lane transfer.
    push     = in_valid && ((level_q < LW'(FIFO_DEPTH)) || pop);
    drop     = in_valid && !push;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_d     = lane_q;
    beat_cnt_d = beat_cnt_q;
    overflow_d = overflow_q;

    if (xfer) begin
      lane_d = lane_end ? '0 : lane_q + NW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      beat_cnt_d = (beat_cnt_q == BW'(PKT_BEATS - 1)) ?
                   '0 : beat_cnt_q + BW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);

    // A drop in the same cycle as a clear wins.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      lane_q     <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      lane_q     <= lane_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = valid;
    out_data  = '0;
    if (valid) begin
      out_data = head[int'(lane_q)*DATA_OUTPUT +: DATA_OUTPUT];
    end
    out_last   = valid && lane_end &&
                 (beat_cnt_q == BW'(PKT_BEATS - 1));
    overflow   = overflow_q;
    fifo_level = level_q;
  end

endmodule

// File: tb/tb_baseline_sample_serializer.sv
// tb_baseline_sample_serializer: directed and random stimulus against a
// queue-of-beats reference model of the sample serializer.
module tb_baseline_sample_serializer;

  localparam int DW    = 17;
  localparam int LANES = 16;
  localparam int DEPTH = 4;
  localparam int PKT   = 64;
  localparam int PKT_S = LANES * PKT;

  typedef logic [DW*LANES-1:0] beat_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  beat_t             in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              overflow;
  logic              clr_overflow;
  logic [2:0]        fifo_level;

  baseline_sample_serializer #(
    .DATA_OUTPUT(DW),
    .LANES(LANES),
    .FIFO_DEPTH(DEPTH),
    .PKT_BEATS(PKT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .overflow(overflow),
    .clr_overflow(clr_overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: stored beats, position in head beat,
  // samples delivered since reset, sticky drop flag
  beat_t m_q[$];
  int    m_lane;
  int    m_idx;
  bit    m_ovf;
  int    n_xfer;
  int    n_last;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_q.delete();
    m_lane = 0;
    m_idx  = 0;
    m_ovf  = 0;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < LANES; k++) b[k*DW +: DW] = DW'($urandom);
    return b;
  endfunction

  function automatic beat_t ramp_beat(input int base);
    beat_t b;
    for (int k = 0; k < LANES; k++) b[k*DW +: DW] = DW'(base + k + 1);
    return b;
  endfunction

  task automatic step();
    beat_t         hb;
    logic [DW-1:0] ed;
    logic          ev;
    logic          el;
    bit            drop;
    ev = (m_q.size() != 0);
    ed = '0;
    if (ev) begin
      hb = m_q[0];
      ed = hb[m_lane*DW +: DW];
    end
    el = ev && ((m_idx % PKT_S) == PKT_S - 1);
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("out_last", 32'(out_last), 32'(el));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (out_valid && out_ready) begin
      n_xfer++;
      if (out_last) n_last++;
    end
    @(posedge clk);
    drop = 0;
    if (rst) begin
      m_clear();
    end else begin
      if (ev && out_ready) begin
        m_idx++;
        m_lane++;
        if (m_lane == LANES) begin
          m_lane = 0;
          m_q.delete(0);
        end
      end
      if (in_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(in_data);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
    #1;
  endtask

  task automatic send(input beat_t b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    m_clear();
    n_xfer = 0;
    n_last = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);

    // single beat, ramp 1..16, always ready
    out_ready = 1'b1;
    idle(2);
    n_xfer = 0;
    send(ramp_beat(0));
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_lane0", 32'(out_data), 1);
    idle(20);
    chk("single_xfers", n_xfer, 16);
    chk("single_level", 32'(fifo_level), 0);

    // backpressure pattern 1,0,0,1,...
    n_xfer = 0;
    send(ramp_beat(0));
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 3 == 0);
      step();
    end
    chk("bp_xfers", n_xfer, 16);

    // overflow: six beats with the output stalled
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) send(ramp_beat(t * 256));
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    n_xfer = 0;
    out_ready = 1'b1;
    idle(80);
    chk("ovf_xfers", n_xfer, 64);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // full FIFO, new beat on the head's final-lane transfer
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) send(rand_beat());
    out_ready = 1'b1;
    idle(15);
    send(rand_beat());
    chk("fp_ovf", 32'(overflow), 0);
    chk("fp_level", 32'(fifo_level), 4);
    idle(90);

    // packet framing: 130 beats, one every 16 cycles
    do_reset();
    n_last = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 130; t++) begin
      send(rand_beat());
      idle(15);
    end
    idle(40);
    chk("pkt_lasts", n_last, 2);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 11) == 0);
      in_data      = rand_beat();
      out_ready    = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid     = 1'b0;
    clr_overflow = 1'b0;
    out_ready    = 1'b1;
    idle(100);

    // reset mid-beat with two beats held and overflow set
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) send(rand_beat());
    out_ready = 1'b1;
    idle(35);
    chk("pre_rst_level", 32'(fifo_level), 2);
    chk("pre_rst_ovf", 32'(overflow), 1);
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    send(ramp_beat(100));
    chk("post_rst_lane0", 32'(out_data), 101);

    // clear coinciding with a drop keeps overflow set
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) send(rand_beat());
    clr_overflow = 1'b1;
    send(rand_beat());
    clr_overflow = 1'b0;
    chk("clr_vs_drop", 32'(overflow), 1);
    out_ready = 1'b1;
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
